// File: rtl/regfile_sweep.sv
// regfile_sweep: 32x32 register file, r0 = 0, post-reset clear sweep; REGFILE_BYPASS_EN adds write-to-read bypass
module regfile_sweep #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 5
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  ctrl_writeEn,
    input  logic [DEPTH_LOG2-1:0] ctrl_writeReg,
    input  logic [WIDTH-1:0]      data_writeReg,
    input  logic [DEPTH_LOG2-1:0] ctrl_readRegA,
    input  logic [DEPTH_LOG2-1:0] ctrl_readRegB,
    output logic [WIDTH-1:0]      data_readRegA,
    output logic [WIDTH-1:0]      data_readRegB,
    output logic                  ctrl_busy
);
    typedef enum logic {CLEAR, IDLE} state_t;
    state_t                  state, state_nx;
    logic [DEPTH_LOG2-1:0]   ptr, ptr_nx, wa;
    logic [WIDTH-1:0]        wd;
    logic                    we, user_we, fwd_a, fwd_b;
    logic [WIDTH-1:0]        mem [0:(1<<DEPTH_LOG2)-1];
    assign user_we = state == IDLE && ctrl_writeEn && ctrl_writeReg != '0;
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        we       = user_we;
        wa       = ctrl_writeReg;
        wd       = data_writeReg;
        if (state == CLEAR) begin
            we       = 1'b1;
            wa       = ptr;
            wd       = '0;
            ptr_nx   = ptr + 1'b1;
            state_nx = ptr == '1 ? IDLE : CLEAR;
        end
    end
    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            state <= CLEAR;
            ptr   <= DEPTH_LOG2'(1);
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
        end
    end
    always_ff @(posedge clock)
        if (ctrl_reset && we)
            mem[wa] <= wd;
`ifdef REGFILE_BYPASS_EN
    assign fwd_a = user_we && ctrl_writeReg == ctrl_readRegA;
    assign fwd_b = user_we && ctrl_writeReg == ctrl_readRegB;
`else
    assign fwd_a = 1'b0;
    assign fwd_b = 1'b0;
`endif
    assign ctrl_busy     = state == CLEAR;
    assign data_readRegA = (ctrl_busy || ctrl_readRegA == '0) ? '0 : fwd_a ? data_writeReg : mem[ctrl_readRegA];
    assign data_readRegB = (ctrl_busy || ctrl_readRegB == '0) ? '0 : fwd_b ? data_writeReg : mem[ctrl_readRegB];
endmodule

// File: tb/tb_regfile_sweep.sv
// tb_regfile_sweep: random and directed stimulus checked against a behavioural register-file model
module tb_regfile_sweep;
    logic        clock = 1'b0;
    logic        ctrl_reset = 1'b0;
    logic        ctrl_writeEn = 1'b0;
    logic [4:0]  ctrl_writeReg = '0;
    logic [31:0] data_writeReg = '0;
    logic [4:0]  ctrl_readRegA = '0;
    logic [4:0]  ctrl_readRegB = '0;
    logic [31:0] data_readRegA, data_readRegB;
    logic        ctrl_busy;
    int compared = 0;
    int mismatched = 0;
    logic [31:0] m [0:31];
    int left = 31;
    bit checking = 0;

    regfile_sweep dut (
        .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEn(ctrl_writeEn),
        .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
        .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
        .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
        .ctrl_busy(ctrl_busy)
    );

    always #5 clock = ~clock;

    // model: a sweep is a 31-cycle countdown that leaves every register zero
    always @(posedge clock) begin
        if (!ctrl_reset) begin
            left     <= 31;
            checking <= 1;
        end else if (left > 0) begin
            left <= left - 1;
            if (left == 1)
                for (int i = 0; i < 32; i++) m[i] <= '0;
        end else if (ctrl_writeEn && ctrl_writeReg != 0)
            m[ctrl_writeReg] <= data_writeReg;
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (left != 0 || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (ctrl_writeEn && ctrl_writeReg != 0 && ctrl_writeReg == a) return data_writeReg;
`endif
        return m[a];
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clock) if (checking) begin
        check("busy", {31'd0, ctrl_busy}, {31'd0, left != 0});
        check("rdA", data_readRegA, exp_rd(ctrl_readRegA));
        check("rdB", data_readRegB, exp_rd(ctrl_readRegB));
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        ctrl_writeEn = 1; ctrl_writeReg = a; data_writeReg = d;
        step();
        ctrl_writeEn = 0;
    endtask

    task automatic count_sweep(input string name);
        int n = 0;
        do begin
            step();
            n++;
        end while (ctrl_busy && n < 40);
        check(name, n, 31);
    endtask

    task automatic rd_lit(input string name, input logic [4:0] a, input logic [31:0] exp);
        ctrl_readRegA = a; ctrl_readRegB = a;
        #1;
        check({name, "_A"}, data_readRegA, exp);
        check({name, "_B"}, data_readRegB, exp);
    endtask

    initial begin
        ctrl_readRegA = 5; ctrl_readRegB = 5;
        step(); step();
        check("rst_busy", {31'd0, ctrl_busy}, 32'd1);
        check("rst_rdA", data_readRegA, 32'd0);
        ctrl_reset = 1;
        count_sweep("sweep_len");
        rd_lit("r5_after", 5, 0);
        for (int i = 1; i < 32; i++) wr(5'(i), 32'h0000DEAD);
        for (int i = 1; i < 32; i++) rd_lit("dead", 5'(i), 32'h0000DEAD);
        wr(0, 32'h0000DEAD);
        rd_lit("r0", 0, 0);
        ctrl_reset = 0; step(); ctrl_reset = 1;
        ctrl_writeEn = 1; ctrl_writeReg = 7; data_writeReg = 32'h12345678;
        count_sweep("sweep_wr");
        ctrl_writeEn = 0;
        rd_lit("r7_drop", 7, 0);
        for (int i = 1; i < 32; i++) wr(5'(i), 32'(i));
        rd_lit("fill", 17, 17);
        ctrl_reset = 0; step(); ctrl_reset = 1;
        count_sweep("sweep_fill");
        rd_lit("clr1", 1, 0);
        rd_lit("clr31", 31, 0);
        ctrl_reset = 0; step(); ctrl_reset = 1;
        repeat (10) step();
        ctrl_reset = 0; step(); ctrl_reset = 1;
        count_sweep("sweep_restart");
        ctrl_writeEn = 0; data_writeReg = 32'hDEAD;
        for (int i = 0; i < 32; i++) begin ctrl_writeReg = 5'(i); step(); end
        rd_lit("no_we", 3, 0);
        ctrl_readRegA = 9;
        ctrl_writeEn = 1; ctrl_writeReg = 9; data_writeReg = 32'hCAFEF00D;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("byp_same", data_readRegA, 32'hCAFEF00D);
`else
        check("byp_same", data_readRegA, 32'h0);
`endif
        step();
        ctrl_writeEn = 0;
        #1;
        check("byp_next", data_readRegA, 32'hCAFEF00D);
        for (int c = 0; c < 3000; c++) begin
            ctrl_reset    = $urandom_range(0, 299) != 0;
            ctrl_writeEn  = $urandom_range(0, 1);
            ctrl_writeReg = 5'($urandom);
            data_writeReg = $urandom;
            ctrl_readRegA = $urandom_range(0, 3) == 0 ? ctrl_writeReg : 5'($urandom);
            ctrl_readRegB = $urandom_range(0, 3) == 0 ? ctrl_writeReg : 5'($urandom);
            step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/regfile_sweep.md
# regfile_sweep

32 × 32-bit register file for the processor datapath: two combinational read ports, one write port, r0 hardwired to zero. Storage is an un-reset array, so reset launches a sequential clear sweep that writes zero to r1..r31 one register per cycle; `ctrl_busy` flags the sweep. An optional write-to-read bypass is compiled in by macro.

## Interface
- `WIDTH`, 32, data width of each register
- `DEPTH_LOG2`, 5, register address width (2^5 = 32 registers)
- `clock`  in  1  single clock; all state updates on posedge
- `ctrl_reset`  in  1  synchronous, active-low reset, sampled on posedge
- `ctrl_writeEn`  in  1  write request, sampled on posedge
- `ctrl_writeReg`  in  5  write address
- `data_writeReg`  in  32  write data
- `ctrl_readRegA`  in  5  read address, port A
- `ctrl_readRegB`  in  5  read address, port B
- `data_readRegA`  out  32  read data, port A (combinational)
- `data_readRegB`  out  32  read data, port B (combinational)
- `ctrl_busy`  out  1  high while in reset or clear sweep; writes are dropped

## Operation
- FSM states: CLEAR, IDLE. 5-bit sweep pointer `ptr`.
- `ctrl_reset`=0 at posedge: state←CLEAR, ptr←1, no array write. Overrides all other activity.
- CLEAR, reset high: array[ptr]←0, ptr←ptr+1. On the write with ptr=31: state←IDLE. The sweep covers r1..r31, exactly 31 cycles after reset release.
- IDLE: if `ctrl_writeEn`=1 and `ctrl_writeReg`≠0, array[ctrl_writeReg]←data_writeReg at posedge. A write to r0 is discarded.
- CLEAR: user writes are discarded. There is no queueing and no error indication.
- Reads: address 0 returns 0. While `ctrl_busy`=1, both ports return 0 for every address. In IDLE, each port returns array[addr].
- Both ports may read the same address simultaneously with identical results.
- `ctrl_busy` = (state==CLEAR), registered.

## Timing
- Reset values: state=CLEAR, ptr=1, `ctrl_busy`=1, `data_readRegA/B`=0.
- Sweep latency: `ctrl_busy` falls at the 31st posedge after the first posedge that samples `ctrl_reset`=1.
- Reset re-asserted mid-sweep: ptr returns to 1 and the full 31-cycle sweep restarts after release.
- Write latency: a write sampled at posedge N is visible on the read ports after posedge N (same cycle, combinationally).
- Write and read to the same address in the same cycle: the read returns the old value unless the bypass is compiled in.
- A write sampled on the same posedge at which state moves CLEAR→IDLE is dropped. The first accepted write is at the first posedge where `ctrl_busy`=1 is no longer the registered value.
- `ctrl_writeReg` and read addresses wrap naturally over 5 bits. There are no out-of-range addresses.

## Configuration
- `REGFILE_BYPASS_EN` defined: in IDLE, if `ctrl_writeEn`=1, `ctrl_writeReg`≠0 and `ctrl_writeReg`==read address, that port returns `data_writeReg` combinationally in the same cycle. A write to r0 is never bypassed. No bypass during CLEAR.
- `REGFILE_BYPASS_EN` undefined: no forwarding. The read returns stored contents only.

## Test plan
- Reset 2 cycles, release -> `ctrl_busy`=1 for exactly 31 posedges, then 0. Read of r5 returns 0 throughout and after.
- After the sweep, write r1..r31 with 0x0000DEAD then read each on A and B -> 0x0000DEAD. Write r0 with 0x0000DEAD -> r0 reads 0.
- With writes issued while `ctrl_busy`=1 (r7←0x12345678) -> after the sweep, r7 reads 0.
- Fill r1..r31 with index value, pulse reset for 1 cycle, wait 31 cycles -> all registers read 0. Re-assert reset at sweep cycle 10 -> `ctrl_busy` remains high for a full 31 more cycles after the second release.
- With `ctrl_writeEn`=0, drive addresses 0..31 with data 0xDEAD each cycle -> all registers unchanged (0).
- Same-cycle write r9←0xCAFEF00D with port A reading r9 -> port A returns 0xCAFEF00D that cycle with `REGFILE_BYPASS_EN`, and the old value without it. Both builds read 0xCAFEF00D on the next cycle.
